// File: rtl/sseg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// sseg_scan_ctrl
//
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment
// display. Each digit gets a slot of PRESCALE clocks: BLANK clocks with all
// anodes off (anti-ghosting), then PRESCALE-BLANK clocks showing the digit.
// New values arrive over a valid/ready handshake into a one-entry pending
// buffer and are copied to the shown value only at a frame boundary (or
// while the scan is off), so a frame never mixes two values.
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         asynchronous active-high reset
//   en          scan enable; 0 = display dark
//   upd_valid   new value offered
//   upd_ready   controller can accept a new value (registered)
//   upd_bcd     BCD digits, [3:0] ones .. [15:12] thousands
//   upd_dp      decimal point per digit, 1 = lit, bit i = digit i
//   lz_sup      leading-zero suppression enable (sampled live)
//   digit_code  nibble to BCD-to-segment decoder, 4'hF = blank
//   dp          decimal point, active-low
//   an          anodes, active-low, digit i = bit i
//   frame_done  one-cycle pulse after the last show cycle of digit 3
// ----------------------------------------------------------------------------
module sseg_scan_ctrl #(
    parameter int PRESCALE = 100000,  // clocks per digit slot, must exceed BLANK
    parameter int BLANK    = 1000     // blank clocks at slot start, 0 = none
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [15:0] upd_bcd,
    input  logic [3:0]  upd_dp,
    input  logic        lz_sup,
    output logic [3:0]  digit_code,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int CW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SHOW_LEN = PRESCALE - BLANK;

    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_LEN - 1);

    typedef enum logic [1:0] {
        S_OFF,
        S_BLANK,
        S_SHOW
    } state_t;

    // With no blanking, every slot starts directly in SHOW.
    localparam state_t SLOT_START = (BLANK > 0) ? S_BLANK : S_SHOW;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;

    logic [15:0]   active_bcd_q, active_bcd_d;
    logic [3:0]    active_dp_q, active_dp_d;
    logic [15:0]   pend_bcd_q, pend_bcd_d;
    logic [3:0]    pend_dp_q, pend_dp_d;
    logic          full_q, full_d;
    logic          upd_ready_q, upd_ready_d;

    logic [3:0]    an_q, an_d;
    logic [3:0]    code_q, code_d;
    logic          dp_q, dp_d;
    logic          frame_done_q, frame_done_d;

    logic          transfer;
    logic          boundary;
    logic          commit;

    // Decoder code for one digit. A digit is blanked under suppression when
    // it and every more significant digit are zero; the ones digit always
    // shows. Non-BCD nibbles pass through untouched.
    function automatic logic [3:0] digit_sel(input logic [15:0] v,
                                             input logic [1:0]  i,
                                             input logic        lz);
        logic [3:0] nib;
        logic       zero_above;
        nib        = v[4*i +: 4];
        zero_above = 1'b0;
        case (i)
            2'd3:    zero_above = (v[15:12] == 4'h0);
            2'd2:    zero_above = (v[15:8]  == 8'h00);
            2'd1:    zero_above = (v[15:4]  == 12'h000);
            default: zero_above = 1'b0;
        endcase
        return (lz && zero_above) ? 4'hF : nib;
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        boundary     = 1'b0;

        transfer = upd_valid && upd_ready_q;

        if (!en) begin
            // Abandon any partial frame; no frame_done for it.
            state_d = S_OFF;
            cnt_d   = '0;
            idx_d   = 2'd0;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d = SLOT_START;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                end
                S_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = S_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = SLOT_START;
                        cnt_d   = '0;
                        idx_d   = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            boundary     = 1'b1;
                            frame_done_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                end
            endcase
        end

        // A transfer needs full=0 and a commit needs full=1, so the two
        // never collide on the same cycle.
        commit = full_q && (boundary || (state_q == S_OFF));

        active_bcd_d = active_bcd_q;
        active_dp_d  = active_dp_q;
        pend_bcd_d   = pend_bcd_q;
        pend_dp_d    = pend_dp_q;
        full_d       = full_q;

        if (transfer) begin
            pend_bcd_d = upd_bcd;
            pend_dp_d  = upd_dp;
            full_d     = 1'b1;
        end
        if (commit) begin
            active_bcd_d = pend_bcd_q;
            active_dp_d  = pend_dp_q;
            full_d       = 1'b0;
        end

        upd_ready_d = !full_d;

        // Outputs are derived from next-state values so the registered
        // outputs line up with the state they belong to; this also lets a
        // freshly committed value show on the first digit of the new frame.
        an_d   = 4'hF;
        code_d = 4'hF;
        dp_d   = 1'b1;
        if (state_d == S_SHOW) begin
            an_d   = ~(4'b0001 << idx_d);
            code_d = digit_sel(active_bcd_d, idx_d, lz_sup);
            dp_d   = ~active_dp_d[idx_d];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_OFF;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            active_bcd_q <= 16'h0000;
            active_dp_q  <= 4'h0;
            pend_bcd_q   <= 16'h0000;
            pend_dp_q    <= 4'h0;
            full_q       <= 1'b0;
            upd_ready_q  <= 1'b1;
            an_q         <= 4'hF;
            code_q       <= 4'hF;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            active_bcd_q <= active_bcd_d;
            active_dp_q  <= active_dp_d;
            pend_bcd_q   <= pend_bcd_d;
            pend_dp_q    <= pend_dp_d;
            full_q       <= full_d;
            upd_ready_q  <= upd_ready_d;
            an_q         <= an_d;
            code_q       <= code_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign upd_ready  = upd_ready_q;
    assign an         = an_q;
    assign digit_code = code_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sseg_scan_ctrl
//
// Directed bench for sseg_scan_ctrl with PRESCALE=8, BLANK=2. Cycle c counts
// from the first BLANK cycle of a scan started from OFF; inputs are driven
// and outputs sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_sseg_scan_ctrl;

    localparam int PRESCALE = 8;
    localparam int BLANK    = 2;

    logic        clk;
    logic        rst;
    logic        en;
    logic        upd_valid;
    logic        upd_ready;
    logic [15:0] upd_bcd;
    logic [3:0]  upd_dp;
    logic        lz_sup;
    logic [3:0]  digit_code;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    sseg_scan_ctrl #(
        .PRESCALE (PRESCALE),
        .BLANK    (BLANK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_bcd    (upd_bcd),
        .upd_dp     (upd_dp),
        .lz_sup     (lz_sup),
        .digit_code (digit_code),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {an, digit_code, dp} at scan cycle c, given the code each
    // digit must show (codes[4i+3:4i] for digit i) and the dp bits.
    function automatic logic [8:0] exp_vec(input int c,
                                           input logic [15:0] codes,
                                           input logic [3:0]  dpv);
        int         s;
        int         pos;
        logic [3:0] a;
        s   = (c / PRESCALE) % 4;
        pos = c % PRESCALE;
        if (pos < BLANK)
            return {4'hF, 4'hF, 1'b1};
        a    = 4'hF;
        a[s] = 1'b0;
        return {a, codes[s*4 +: 4], ~dpv[s]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load a value while the scan is off: transfer, then commit in OFF.
    task automatic load(input logic [15:0] v, input logic [3:0] d);
        upd_bcd   = v;
        upd_dp    = d;
        upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic stop_scan();
        en = 1'b0;
        tick();
        tick();
    endtask

    task automatic start_scan();
        en = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; upd_valid = 1'b0; upd_bcd = '0; upd_dp = '0; lz_sup = 1'b0;
        tick();
        tick();
        checks++;
        if ({an, digit_code, dp, upd_ready, frame_done} !== {4'hF, 4'hF, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got an=%b code=%h dp=%b rdy=%b fd=%b exp an=1111 code=f dp=1 rdy=1 fd=0",
                     an, digit_code, dp, upd_ready, frame_done);
        end
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({an, digit_code, dp, upd_ready, frame_done} !== {4'hF, 4'hF, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL off_after_reset got an=%b code=%h dp=%b rdy=%b fd=%b exp an=1111 code=f dp=1 rdy=1 fd=0",
                     an, digit_code, dp, upd_ready, frame_done);
        end
    endtask

    task automatic test_scan();
        load(16'h1234, 4'b0000);
        start_scan();
        for (int c = 0; c < 34; c++) begin
            checks++;
            if ({an, digit_code, dp} !== exp_vec(c, 16'h1234, 4'b0000)) begin
                errors++;
                $display("FAIL scan c=%0d got {an,code,dp}=%b exp %b", c,
                         {an, digit_code, dp}, exp_vec(c, 16'h1234, 4'b0000));
            end
            checks++;
            if (frame_done !== (c == 32)) begin
                errors++;
                $display("FAIL scan_frame_done c=%0d got %b exp %b", c, frame_done, (c == 32));
            end
            tick();
        end
        stop_scan();
    endtask

    task automatic test_update();
        logic [15:0] codes;
        logic [3:0]  dpv;
        start_scan();
        for (int c = 0; c < 64; c++) begin
            if (c == 10) begin
                upd_valid = 1'b1; upd_bcd = 16'h0987; upd_dp = 4'b0010;
            end else begin
                upd_valid = 1'b0;
            end
            codes = (c < 32) ? 16'h1234 : 16'h0987;
            dpv   = (c < 32) ? 4'b0000  : 4'b0010;
            checks++;
            if ({an, digit_code, dp} !== exp_vec(c, codes, dpv)) begin
                errors++;
                $display("FAIL update_scan c=%0d got %b exp %b", c,
                         {an, digit_code, dp}, exp_vec(c, codes, dpv));
            end
            checks++;
            if (upd_ready !== !(c >= 11 && c <= 31)) begin
                errors++;
                $display("FAIL update_ready c=%0d got %b exp %b", c, upd_ready, !(c >= 11 && c <= 31));
            end
            checks++;
            if (frame_done !== (c == 32)) begin
                errors++;
                $display("FAIL update_frame_done c=%0d got %b exp %b", c, frame_done, (c == 32));
            end
            tick();
        end
        upd_valid = 1'b0;
        stop_scan();
    endtask

    task automatic test_lz();
        logic [15:0] vals [3]   = '{16'h0050, 16'h0000, 16'h0000};
        logic        lzs  [3]   = '{1'b1, 1'b1, 1'b0};
        logic [15:0] codes [3]  = '{16'hFF50, 16'hFFF0, 16'h0000};
        for (int t = 0; t < 3; t++) begin
            lz_sup = lzs[t];
            load(vals[t], 4'b0000);
            start_scan();
            for (int c = 0; c < 32; c++) begin
                checks++;
                if ({an, digit_code, dp} !== exp_vec(c, codes[t], 4'b0000)) begin
                    errors++;
                    $display("FAIL lz case=%0d c=%0d got %b exp %b", t, c,
                             {an, digit_code, dp}, exp_vec(c, codes[t], 4'b0000));
                end
                tick();
            end
            stop_scan();
        end
        lz_sup = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] codes;
        logic        rdy_exp;
        load(16'h1111, 4'b0000);
        start_scan();
        upd_dp = 4'b0000;
        for (int c = 0; c < 96; c++) begin
            upd_valid = (c >= 4 && c <= 32);
            upd_bcd   = (c < 5) ? 16'h2222 : 16'h3333;
            codes     = (c < 32) ? 16'h1111 : ((c < 64) ? 16'h2222 : 16'h3333);
            rdy_exp   = !((c >= 5 && c <= 31) || (c >= 33 && c <= 63));
            checks++;
            if ({an, digit_code, dp} !== exp_vec(c, codes, 4'b0000)) begin
                errors++;
                $display("FAIL b2b_scan c=%0d got %b exp %b", c,
                         {an, digit_code, dp}, exp_vec(c, codes, 4'b0000));
            end
            checks++;
            if (upd_ready !== rdy_exp) begin
                errors++;
                $display("FAIL b2b_ready c=%0d got %b exp %b", c, upd_ready, rdy_exp);
            end
            checks++;
            if (frame_done !== (c == 32 || c == 64)) begin
                errors++;
                $display("FAIL b2b_frame_done c=%0d got %b exp %b", c, frame_done, (c == 32 || c == 64));
            end
            tick();
        end
        upd_valid = 1'b0;
        stop_scan();
    endtask

    task automatic test_en_drop();
        load(16'h1234, 4'b0000);
        start_scan();
        for (int c = 0; c <= 20; c++) begin
            if (c == 12) begin
                upd_valid = 1'b1; upd_bcd = 16'h5678; upd_dp = 4'b0001;
            end else begin
                upd_valid = 1'b0;
            end
            checks++;
            if ({an, digit_code, dp} !== exp_vec(c, 16'h1234, 4'b0000)) begin
                errors++;
                $display("FAIL drop_scan c=%0d got %b exp %b", c,
                         {an, digit_code, dp}, exp_vec(c, 16'h1234, 4'b0000));
            end
            checks++;
            if (upd_ready !== (c <= 12)) begin
                errors++;
                $display("FAIL drop_ready c=%0d got %b exp %b", c, upd_ready, (c <= 12));
            end
            if (c < 20) tick();
        end
        en = 1'b0;
        tick();
        checks++;
        if ({an, digit_code, dp, upd_ready, frame_done} !== {4'hF, 4'hF, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL drop_off got an=%b code=%h dp=%b rdy=%b fd=%b exp an=1111 code=f dp=1 rdy=0 fd=0",
                     an, digit_code, dp, upd_ready, frame_done);
        end
        tick();
        checks++;
        if (upd_ready !== 1'b1) begin
            errors++;
            $display("FAIL drop_commit_ready got %b exp 1", upd_ready);
        end
        for (int k = 0; k < 12; k++) begin
            checks++;
            if ({an, frame_done} !== {4'hF, 1'b0}) begin
                errors++;
                $display("FAIL drop_dark k=%0d got an=%b fd=%b exp an=1111 fd=0", k, an, frame_done);
            end
            tick();
        end
        start_scan();
        for (int c = 0; c < PRESCALE; c++) begin
            checks++;
            if ({an, digit_code, dp} !== exp_vec(c, 16'h5678, 4'b0001)) begin
                errors++;
                $display("FAIL drop_new_value c=%0d got %b exp %b", c,
                         {an, digit_code, dp}, exp_vec(c, 16'h5678, 4'b0001));
            end
            tick();
        end
        stop_scan();
    endtask

    task automatic test_async_reset();
        load(16'h1234, 4'b0000);
        start_scan();
        for (int c = 0; c < 10; c++) tick();
        upd_valid = 1'b1; upd_bcd = 16'h9999; upd_dp = 4'b1111;
        tick();
        upd_valid = 1'b0;
        checks++;
        if ({an, digit_code, upd_ready} !== {4'b1101, 4'h3, 1'b0}) begin
            errors++;
            $display("FAIL pre_reset got an=%b code=%h rdy=%b exp an=1101 code=3 rdy=0",
                     an, digit_code, upd_ready);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({an, digit_code, dp, upd_ready, frame_done} !== {4'hF, 4'hF, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got an=%b code=%h dp=%b rdy=%b fd=%b exp an=1111 code=f dp=1 rdy=1 fd=0",
                     an, digit_code, dp, upd_ready, frame_done);
        end
        #2;
        rst = 1'b0;
        tick();
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({an, digit_code, dp} !== exp_vec(c, 16'h0000, 4'b0000)) begin
                errors++;
                $display("FAIL reset_restart c=%0d got %b exp %b", c,
                         {an, digit_code, dp}, exp_vec(c, 16'h0000, 4'b0000));
            end
            checks++;
            if (upd_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_restart_ready c=%0d got %b exp 1", c, upd_ready);
            end
            tick();
        end
        stop_scan();
    endtask

    initial begin
        test_reset();
        test_scan();
        test_update();
        test_lz();
        test_back_to_back();
        test_en_drop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
